riscv_str_xform: RTL and testbench
==================================

# riscv_str_xform

Parametrised multi-cycle string-transform functional unit for the EX stage, generalising the existing string-ops unit to an arbitrary number of byte lanes. It supports a configurable number of leet-substitution passes and adds ROT13. Every operation is registered and follows one uniform FSM handshake with the EX stage. It takes a packed word of ASCII bytes and returns the transformed word, holding ex_ready low in the pipeline until the result is valid.

## Interface
- NBYTES, default 4: byte lanes per operand; data width W = 8*NBYTES; legal range 1..16.
- LEET_STEPS, default 3: number of leet passes (1..6), applied one per cycle in the fixed order E→'3', S→'5', L→'1', O→'0', A→'4', T→'7'.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  operation request from EX; held high while the instruction sits in EX
- operator_i  in  STR_OP_WIDTH  STR_OP_UPPER / STR_OP_LOWER / STR_OP_LEET / STR_OP_ROT13 (riscv_defines encodings)
- operand_i  in  W  packed input bytes; byte i = operand_i[8i+:8]
- ex_ready_i  in  1  EX stage consumes the result this cycle
- result_o  out  W  transformed word; valid when valid_o=1
- valid_o  out  1  result available (state DONE)
- ready_o  out  1  unit not stalling EX
- busy_o  out  1  operation in flight (state STEP)

## Operation
- FSM states and transitions:
  - IDLE: on enable_i=1, capture the operand into the internal register (transformed as below). UPPER/LOWER/ROT13/unknown operators go to DONE; LEET goes to STEP with cnt=0.
  - STEP: apply leet pass cnt to every lane, then cnt++. When cnt = LEET_STEPS-1 at the edge, go to DONE.
  - DONE: hold result. On ex_ready_i=1, go to IDLE.
- DONE never re-accepts enable_i, even with ex_ready_i=1. That enable belongs to the retiring instruction; a new op is accepted from IDLE on the next cycle.
- Per-lane functions (unsigned bytes, all lanes independent):
  - UPPER: 0x61..0x7A → −0x20.
  - LOWER: 0x41..0x5A → +0x20.
  - ROT13: letters rotate 13 within their case, with wrap (e.g. 'z'→'m').
  - LEET pass k: replaces its upper- and lower-case letter with its digit.
  - All other bytes pass through unchanged.
- Unknown operator: operand passes through unchanged, with 1-cycle latency.
- operand_i and operator_i are sampled only at acceptance; changes afterwards are ignored.
- ready_o = (IDLE & !enable_i) | DONE.
- valid_o = DONE.
- busy_o = STEP.
- result_o drives the internal register in every state; its content is only meaningful when valid_o=1.

## Timing
- Reset (asynchronous, any state, including mid-LEET): state IDLE, cnt 0, result register 0, result_o=0, valid_o=0, busy_o=0. ready_o=1 whenever enable_i=0.
- Latency, with the accept cycle counted as cycle 0:
  - UPPER/LOWER/ROT13/unknown: valid_o=1 in cycle 1.
  - LEET: valid_o=1 in cycle LEET_STEPS+1.
- DONE persists for as many cycles as ex_ready_i stays low; result_o stays stable throughout.
- Back-to-back ops: minimum spacing is one IDLE cycle between the DONE-exit edge and the next accept.
- A cycle with enable_i=0 in IDLE leaves the result register unchanged.
- Critical path: one substitution compare per lane; no lane-to-lane carry.

## Configuration
- STR_XFORM_ROT13_EN defined: ROT13 is implemented as specified.
- STR_XFORM_ROT13_EN undefined: the ROT13 logic is removed. STR_OP_ROT13 takes the unknown-operator path, so the operand passes through unchanged with 1-cycle latency. The handshake and timing are identical in both builds.

## Test plan
- Reset / idle: assert rst_n=0 mid-LEET (busy_o=1), then release → result_o=0, valid_o=0, busy_o=0, and ready_o=1 with enable_i=0.
- UPPER then LOWER (NBYTES=4):
  - UPPER of 0x6C6C6548 ("Hell") → result 0x4C4C4548 in cycle 1.
  - LOWER of 0x4C4C4548 → 0x6C6C6568.
  - LOWER of 0x5B404160 → 0x5B406160; boundary bytes 0x5B, 0x40, 0x60 are untouched.
- LEET, LEET_STEPS=3: operand 0x6C6C6548 → ready_o=0 and busy_o=1 for cycles 1–3, then valid_o=1 in cycle 4 with result 0x31313348.
- ROT13, macro defined: 0x7A4E6261 ("abNz") → 0x6D416F6E. With the macro undefined, the same operand returns 0x7A4E6261.
- DONE hold / no re-accept: keep ex_ready_i=0 for 5 cycles → result_o stable and valid_o=1. Then raise ex_ready_i with enable_i still 1 → the unit goes to IDLE without a second execution, and busy_o stays 0.
- Operand change: change operand_i to 0xFFFFFFFF one cycle after a LEET accept → the result still equals the transform of the originally captured operand. Repeat with NBYTES=8 for both lane halves.

Source files
------------

// File: rtl/riscv_str_xform_if.sv
// riscv_str_xform_if: EX-stage handshake between the pipeline (master) and the string unit (slave).
interface riscv_str_xform_if #(
    parameter int NBYTES = 4
) ();
    localparam int STR_OP_WIDTH = 3;
    logic                    enable_i;
    logic [STR_OP_WIDTH-1:0] operator_i;
    logic [8*NBYTES-1:0]     operand_i;
    logic                    ex_ready_i;
    logic [8*NBYTES-1:0]     result_o;
    logic                    valid_o;
    logic                    ready_o;
    logic                    busy_o;
    modport master (
        output enable_i, operator_i, operand_i, ex_ready_i,
        input  result_o, valid_o, ready_o, busy_o
    );
    modport slave (
        input  enable_i, operator_i, operand_i, ex_ready_i,
        output result_o, valid_o, ready_o, busy_o
    );
endinterface

// File: rtl/riscv_str_xform.sv
// riscv_str_xform: multi-lane UPPER/LOWER/LEET/ROT13 string unit with an IDLE/STEP/DONE handshake.
// ROT13 is built only when STR_XFORM_ROT13_EN is defined; otherwise it takes the pass-through path.
module riscv_str_xform #(
    parameter int NBYTES     = 4,
    parameter int LEET_STEPS = 3
) (
    input logic               clk,
    input logic               rst_n,
    riscv_str_xform_if.slave  bus
);
    localparam int W = 8 * NBYTES;
    localparam logic [2:0] STR_OP_UPPER = 3'd0;
    localparam logic [2:0] STR_OP_LOWER = 3'd1;
    localparam logic [2:0] STR_OP_LEET  = 3'd2;
    localparam logic [2:0] STR_OP_ROT13 = 3'd3;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t         state;
    logic [2:0]     cnt;
    logic [W-1:0]   acc;
    logic [W-1:0]   cap;
    logic [W-1:0]   leeted;
    logic           valid;
    logic           busy;

`ifdef STR_XFORM_ROT13_EN
    function automatic logic [7:0] f_rot(input logic [7:0] b);
        logic lc, uc;
        lc = b >= 8'h61 && b <= 8'h7A;
        uc = b >= 8'h41 && b <= 8'h5A;
        return lc ? (b <= 8'h6D ? b + 8'd13 : b - 8'd13) :
               uc ? (b <= 8'h4D ? b + 8'd13 : b - 8'd13) : b;
    endfunction
`endif

    function automatic logic [7:0] f_xform(input logic [2:0] op, input logic [7:0] b);
`ifdef STR_XFORM_ROT13_EN
        if (op == STR_OP_ROT13) return f_rot(b);
`endif
        return (op == STR_OP_UPPER && b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 :
               (op == STR_OP_LOWER && b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    endfunction

    // Pass k maps one letter (either case) to its digit: E3 S5 L1 O0 A4 T7.
    function automatic logic [7:0] f_leet(input logic [7:0] b, input logic [2:0] k);
        logic [7:0] u, d;
        u = k == 3'd0 ? 8'h45 : k == 3'd1 ? 8'h53 : k == 3'd2 ? 8'h4C :
            k == 3'd3 ? 8'h4F : k == 3'd4 ? 8'h41 : 8'h54;
        d = k == 3'd0 ? 8'h33 : k == 3'd1 ? 8'h35 : k == 3'd2 ? 8'h31 :
            k == 3'd3 ? 8'h30 : k == 3'd4 ? 8'h34 : 8'h37;
        return (b == u || b == (u | 8'h20)) ? d : b;
    endfunction

    always_comb begin
        cap    = '0;
        leeted = '0;
        for (int i = 0; i < NBYTES; i++) begin
            cap[8*i+:8]    = f_xform(bus.operator_i, bus.operand_i[8*i+:8]);
            leeted[8*i+:8] = f_leet(acc[8*i+:8], cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.enable_i) begin
                    acc <= cap;
                    cnt <= '0;
                    if (bus.operator_i == STR_OP_LEET) begin
                        state <= STEP;
                        busy  <= 1'b1;
                    end else begin
                        state <= DONE;
                        valid <= 1'b1;
                    end
                end
                STEP: begin
                    acc <= leeted;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(LEET_STEPS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end
                end
                DONE: if (bus.ex_ready_i) begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o = acc;
    assign bus.valid_o  = valid;
    assign bus.busy_o   = busy;
    assign bus.ready_o  = (state == IDLE && !bus.enable_i) || state == DONE;
endmodule

// File: tb/tb_riscv_str_xform.sv
// tb_riscv_str_xform: directed scoreboard bench driving a 4-lane and an 8-lane unit in lockstep.
module tb_riscv_str_xform;
    localparam logic [2:0] OP_UP = 3'd0, OP_LO = 3'd1, OP_LEET = 3'd2, OP_ROT = 3'd3, OP_BAD = 3'd7;
    localparam int LS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        exr = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] opnd = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] q4[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    riscv_str_xform_if #(.NBYTES(4)) b4 ();
    riscv_str_xform_if #(.NBYTES(8)) b8 ();

    assign b4.enable_i   = en;
    assign b4.operator_i = op;
    assign b4.operand_i  = opnd[31:0];
    assign b4.ex_ready_i = exr;
    assign b8.enable_i   = en;
    assign b8.operator_i = op;
    assign b8.operand_i  = opnd;
    assign b8.ex_ready_i = exr;

    riscv_str_xform #(.NBYTES(4), .LEET_STEPS(LS)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    riscv_str_xform #(.NBYTES(8), .LEET_STEPS(LS)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mb(input logic [2:0] o, input logic [7:0] b);
        string up, dg;
        logic [7:0] r;
        int base;
        up = "ESLOAT";
        dg = "351047";
        r = b;
        if (o == OP_UP && b >= "a" && b <= "z") r = b - 8'd32;
        if (o == OP_LO && b >= "A" && b <= "Z") r = b + 8'd32;
        if (o == OP_LEET)
            for (int k = 0; k < LS; k++)
                if (r == 8'(up[k]) || r == (8'(up[k]) | 8'h20)) r = 8'(dg[k]);
`ifdef STR_XFORM_ROT13_EN
        if (o == OP_ROT && ((b >= "a" && b <= "z") || (b >= "A" && b <= "Z"))) begin
            base = (b >= "a") ? 97 : 65;
            r = 8'(((int'(b) - base + 13) % 26) + base);
        end
`endif
        return r;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] v, input int nb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i+:8] = mb(o, v[8*i+:8]);
        return r;
    endfunction

    // exp4 is the hand-derived 4-lane result; the 8-lane result comes from the model.
    task automatic run(input string tag, input logic [2:0] o, input logic [63:0] v,
                       input logic [31:0] exp4, input int hold, input bit scribble);
        int lat;
        int c;
        logic [63:0] e4, e8;
        lat = (o == OP_LEET) ? LS + 1 : 1;
        @(negedge clk);
        en = 1'b1; op = o; opnd = v; exr = 1'b0;
        q4.push_back({32'h0, exp4});
        q8.push_back(model(o, v, 8));
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (scribble && c == 1) opnd = '1;
            if (!b4.valid_o && c <= LS && o == OP_LEET)
                check({tag, "_step"}, 64'({b4.busy_o, b8.busy_o, b4.ready_o, b8.ready_o}), 64'b1100);
        end while (!b4.valid_o && c < 20);
        check({tag, "_latency"}, 64'(c), 64'(lat));
        e4 = q4.pop_front();
        e8 = q8.pop_front();
        check({tag, "_res4"}, 64'(b4.result_o), e4);
        check({tag, "_res8"}, b8.result_o, e8);
        check({tag, "_done"}, 64'({b8.valid_o, b4.ready_o, b4.busy_o}), 64'b110);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold"}, {b4.result_o, 31'h0, b4.valid_o}, {e4[31:0], 32'h1});
        end
        exr = 1'b1;
        @(negedge clk);
        check({tag, "_retire"}, 64'({b4.valid_o, b4.busy_o, b8.valid_o, b8.busy_o}), 64'b0);
        en = 1'b0; exr = 1'b0;
        #1;
        check({tag, "_idle_ready"}, 64'({b4.ready_o, b8.ready_o}), 64'b11);
        @(negedge clk);
        check({tag, "_no_reexec"}, 64'({b4.valid_o, b4.busy_o, b8.valid_o, b8.busy_o}), 64'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_out", 64'({b4.valid_o, b4.busy_o, b4.ready_o}), 64'b001);
        check("reset_res", b8.result_o, 64'h0);
        rst_n = 1'b1;
        run("upper", OP_UP, 64'h7A617B40_6C6C6548, 32'h4C4C4548, 0, 1'b0);
        run("lower", OP_LO, 64'h4F4B5A41_4C4C4548, 32'h6C6C6568, 0, 1'b0);
        run("lower_edge", OP_LO, 64'h5B404160_5B404160, 32'h5B406160, 0, 1'b0);
        run("leet", OP_LEET, 64'h65734C54_6C6C6548, 32'h31313348, 5, 1'b0);
`ifdef STR_XFORM_ROT13_EN
        run("rot13", OP_ROT, 64'h4D415A6E_7A4E6261, 32'h6D416F6E, 0, 1'b0);
`else
        run("rot13", OP_ROT, 64'h4D415A6E_7A4E6261, 32'h7A4E6261, 0, 1'b0);
`endif
        run("unknown", OP_BAD, 64'h61624142_68656C6C, 32'h68656C6C, 0, 1'b0);
        run("scribble", OP_LEET, 64'h54414F53_6C6C6548, 32'h31313348, 0, 1'b1);
        // Asynchronous reset while a LEET is mid-flight.
        @(negedge clk);
        en = 1'b1; op = OP_LEET; opnd = 64'h6C6C6548_6C6C6548;
        @(negedge clk);
        check("pre_reset_busy", 64'({b4.busy_o, b8.busy_o}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {b4.result_o, 29'h0, b4.valid_o, b4.busy_o, b8.busy_o}, 64'h0);
        check("async_reset8", b8.result_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        #1;
        check("post_reset_ready", 64'({b4.ready_o, b8.ready_o, b4.valid_o}), 64'b110);
        @(negedge clk);
        check("idle_hold_res", 64'(b4.result_o), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
